// File: rtl/gate_logic_unit.sv
// Pipelined two-operand bitwise logic unit with valid/ready handshake on both sides.
// A main result register plus a one-entry skid register keep full throughput under backpressure.
module gate_logic_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               y_all,
  output logic               y_any,
  output logic [COUNT_W-1:0] txn_count
);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = x & z;
      3'b001:  r = x | z;
      3'b010:  r = x ^ z;
      3'b011:  r = ~(x & z);
      3'b100:  r = ~(x | z);
      3'b101:  r = ~(x ^ z);
      3'b110:  r = x;
      3'b111:  r = ~x;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic [WIDTH-1:0]   s_data_q, s_data_d;
  logic               s_valid_q, s_valid_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic             accept_s;
  logic             pop_s;
  logic [WIDTH-1:0] result_s;

  assign in_ready = ~s_valid_q;
  assign accept_s = in_valid & ~s_valid_q;
  assign pop_s    = m_valid_q & out_ready;
  assign result_s = logic_op(op, a, b);

  // Accept is impossible while the skid holds data, so a skid refill never races a new result.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    s_data_d  = s_data_q;
    s_valid_d = s_valid_q;
    if (pop_s && s_valid_q) begin
      m_data_d  = s_data_q;
      m_valid_d = 1'b1;
      s_valid_d = 1'b0;
    end else if (accept_s && (!m_valid_q || pop_s)) begin
      m_data_d  = result_s;
      m_valid_d = 1'b1;
    end else if (accept_s) begin
      s_data_d  = result_s;
      s_valid_d = 1'b1;
    end else if (pop_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  always_comb begin
    if (pop_s) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= {WIDTH{1'b0}};
      m_valid_q <= 1'b0;
      s_data_q  <= {WIDTH{1'b0}};
      s_valid_q <= 1'b0;
      cnt_q     <= {COUNT_W{1'b0}};
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      s_data_q  <= s_data_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign y         = m_data_q;
  assign y_all     = &m_data_q;
  assign y_any     = |m_data_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_gate_logic_unit.sv
// Scoreboard bench for gate_logic_unit: expected results are queued on accept and compared on pop.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_gate_logic_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        out_ready;
  logic        in_ready, out_valid, y_all, y_any;
  logic [7:0]  y;
  logic [15:0] txn_count;
  logic        in_ready4, out_valid4, y_all4, y_any4;
  logic [7:0]  y4;
  logic [3:0]  txn_count4;

  logic [7:0]  q_exp[$];
  int          mcnt;
  int          checks;
  int          failures;
  bit          acc;

  always #5 clk = ~clk;

  gate_logic_unit #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_all(y_all), .y_any(y_any), .txn_count(txn_count)
  );

  gate_logic_unit #(.WIDTH(8), .COUNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .y_all(y_all4), .y_any(y_any4), .txn_count(txn_count4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] sel, input logic [7:0] x, input logic [7:0] z);
    case (sel)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x & z);
      3'd4:    return ~(x | z);
      3'd5:    return ~(x ^ z);
      3'd6:    return x;
      default: return ~x;
    endcase
  endfunction

  // One cycle: drive at negedge, check state, predict the handshake at the next posedge.
  task automatic step(input bit iv, input logic [7:0] av, input logic [7:0] bv,
                      input logic [2:0] ov, input bit ordy, output bit accepted);
    logic [7:0] e;
    bit         can_accept;
    @(negedge clk);
    in_valid  = iv;
    a         = av;
    b         = bv;
    op        = ov;
    out_ready = ordy;
    #1;
    can_accept = (q_exp.size() < 2);
    check_eq("in_ready", in_ready, can_accept);
    check_eq("in_ready_w4", in_ready4, can_accept);
    check_eq("out_valid", out_valid, q_exp.size() > 0);
    check_eq("txn_count", txn_count, mcnt[15:0]);
    check_eq("txn_count_w4", txn_count4, mcnt[3:0]);
    accepted = iv && can_accept;
    if (q_exp.size() > 0 && ordy) begin
      e = q_exp.pop_front();
      check_eq("y", y, e);
      check_eq("y_w4", y4, e);
      check_eq("y_all", y_all, &e);
      check_eq("y_any", y_any, |e);
      mcnt++;
    end
    if (accepted) q_exp.push_back(ref_op(ov, av, bv));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_y", y, 8'h00);
    check_eq("rst_y_all", y_all, 1'b0);
    check_eq("rst_y_any", y_any, 1'b0);
    check_eq("rst_txn_count", txn_count, 16'd0);
    check_eq("rst_txn_count_w4", txn_count4, 4'd0);
    q_exp.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit dummy;
    for (int i = 0; i < budget && q_exp.size() > 0; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, dummy);
    check_eq("drain_empty", q_exp.size(), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; mcnt = 0;
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_reset();

    for (int k = 0; k < 8; k++) step(1'b1, 8'hCA, 8'h5F, 3'(k), 1'b1, acc);
    drain(4);

    // Backpressure: third request must stall until a pop frees the skid.
    step(1'b1, 8'hCA, 8'h5F, 3'd0, 1'b0, acc);
    step(1'b1, 8'h3C, 8'hA5, 3'd2, 1'b0, acc);
    step(1'b1, 8'hF0, 8'h0F, 3'd4, 1'b0, acc);
    step(1'b1, 8'hF0, 8'h0F, 3'd4, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++) step(1'b1, 8'hF0, 8'h0F, 3'd4, 1'b1, acc);
    check_eq("bp_third_accept", acc, 1'b1);
    drain(6);

    do_reset();
    for (int i = 0; i < 100; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)), 1'b1, acc);
    drain(4);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    check_eq("stream_count", txn_count, 16'd100);
    check_eq("stream_count_w4", txn_count4, 4'd4);

    step(1'b1, 8'h81, 8'h7E, 3'd1, 1'b0, acc);
    step(1'b1, 8'hFF, 8'h00, 3'd5, 1'b0, acc);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc);
    do_reset();
    step(1'b1, 8'hFF, 8'hFF, 3'd0, 1'b1, acc);
    step(1'b1, 8'h00, 8'h00, 3'd6, 1'b1, acc);
    drain(4);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
